lfsr_stream_checker: RTL

- Receive end of the 13-bit LFSR random source: consumes the generator's serial feedback-bit stream (one new bit per shift).
- Self-synchronises to that stream, verifies every subsequent bit against the polynomial, counts bit errors and reports lock.
- Re-assembles 13-bit words once every 13 accepted bits, matching the generator's 13-shift output cadence.
- Used as an on-chip checker for the random generator and for any link carrying its stream.

---
 rtl/lfsr_stream_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 13-bit LFSR random source: syncs to the serial
// feedback-bit stream, verifies it against the polynomial, counts errors and rebuilds words.
module lfsr_stream_checker #(
    parameter int LOCK_COUNT  = 26,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 clear_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [12:0]          word_out,
    output logic                 word_valid,
    output logic [1:0]           state_dbg
);

    // Handshake: bit_in is consumed on a rising edge only when bit_valid is high;
    // there is no backpressure. err_pulse and word_valid are single-cycle strobes.

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    logic [12:0]   s;
    logic [3:0]    fill_cnt;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;
    logic [3:0]    phase_cnt;

    logic           pred;
    logic           mismatch;
    logic [12:0]    s_local;
    logic           loss;

    assign pred      = s[12] ^ s[3] ^ s[2] ^ s[0];
    assign mismatch  = (bit_in != pred);
    assign s_local   = {s[11:0], pred};
    assign loss      = mismatch && (win_err == EW'(LOSS_THRESH - 1));
    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= SEARCH;
            s          <= '0;
            fill_cnt   <= '0;
            match_cnt  <= '0;
            win_cnt    <= '0;
            win_err    <= '0;
            phase_cnt  <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            err_pulse  <= 1'b0;
            word_valid <= 1'b0;
            if (bit_valid) begin
                case (state)
                    SEARCH: begin
                        s <= {s[11:0], bit_in};
                        if (fill_cnt == 4'd12) begin
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end else begin
                            fill_cnt <= fill_cnt + 4'd1;
                        end
                    end
                    VERIFY: begin
                        s <= {s[11:0], bit_in};
                        // An all-zero register predicts zeros forever, so it never earns lock.
                        if (!mismatch && (s != 13'd0)) begin
                            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                                match_cnt <= '0;
                                phase_cnt <= '0;
                                win_cnt   <= '0;
                                win_err   <= '0;
                                locked    <= 1'b1;
                                state     <= LOCKED;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running local generator: a corrupted bit is counted once.
                        s <= s_local;
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (err_count != {ERR_CNT_W{1'b1}})
                                err_count <= err_count + ERR_CNT_W'(1);
                        end
                        if (loss) begin
                            fill_cnt <= '0;
                            locked   <= 1'b0;
                            state    <= SEARCH;
                        end else if (win_cnt == WW'(WINDOW - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WW'(1);
                            win_err <= win_err + EW'(mismatch);
                        end
                        if (phase_cnt == 4'd12) begin
                            phase_cnt  <= '0;
                            word_out   <= s_local;
                            word_valid <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + 4'd1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            // Clearing takes priority over a same-edge increment.
            if (clear_err)
                err_count <= '0;
        end
    end

endmodule
